// File: rtl/serial_packet_writer.sv
// Serial-to-parallel framer feeding the SRAM FIFO; tracks FIFO occupancy and gates reads.
// Optional parity stage and parityErr port enabled by defining PARITY_CHECK_EN.
module serial_packet_writer #(
  parameter int BITS  = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serialIn,
  input  logic             bitValid,
  input  logic             frameStart,
  input  logic             readReq,
  output logic             writeMode,
  output logic [BITS-1:0]  packetOut,
  output logic             readMode,
  output logic [DEPTH:0]   fifoCount,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             frameErr
`ifdef PARITY_CHECK_EN
  ,
  output logic             parityErr
`endif
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [DEPTH:0] SLOTS = {1'b1, {DEPTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    COMMIT
  } state_t;

  state_t          state, nextState;
  logic [CW-1:0]   bitCnt, nextCnt;
  logic [BITS-1:0] shiftReg, nextShift, shifted;
  logic            nextFrameErr;
  logic            commit;
  logic            wrAccept;
`ifdef PARITY_CHECK_EN
  logic            nextParityErr;
`endif

  assign shifted  = {shiftReg[BITS-2:0], serialIn};
  assign empty    = (fifoCount == '0);
  assign full     = (fifoCount == SLOTS);
  assign readMode = readReq & ~empty;
  assign wrAccept = commit & ~full;

  always_comb begin
    nextState    = state;
    nextCnt      = bitCnt;
    nextShift    = shiftReg;
    nextFrameErr = 1'b0;
    commit       = 1'b0;
`ifdef PARITY_CHECK_EN
    nextParityErr = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bitValid && frameStart) begin
          nextShift = shifted;
          nextCnt   = CW'(1);
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (bitValid) begin
          nextShift = shifted;
          if (frameStart) begin
            nextFrameErr = 1'b1;
            nextCnt      = CW'(1);
          end else if (bitCnt == CW'(BITS - 1)) begin
            nextCnt = CW'(BITS);
`ifdef PARITY_CHECK_EN
            nextState = PARITY;
`else
            nextState = COMMIT;
`endif
          end else begin
            nextCnt = bitCnt + CW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bitValid) begin
          if (frameStart) begin
            nextShift    = shifted;
            nextFrameErr = 1'b1;
            nextCnt      = CW'(1);
            nextState    = SHIFT;
          end else if (^{shiftReg, serialIn}) begin
            // Odd total parity: drop the packet without touching occupancy
            nextParityErr = 1'b1;
            nextCnt       = '0;
            nextState     = IDLE;
          end else begin
            nextState = COMMIT;
          end
        end
      end
`endif
      COMMIT: begin
        commit    = 1'b1;
        nextCnt   = '0;
        nextState = IDLE;
      end
      default: begin
        nextCnt   = '0;
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      frameErr <= 1'b0;
`ifdef PARITY_CHECK_EN
      parityErr <= 1'b0;
`endif
    end else begin
      state    <= nextState;
      bitCnt   <= nextCnt;
      shiftReg <= nextShift;
      frameErr <= nextFrameErr;
`ifdef PARITY_CHECK_EN
      parityErr <= nextParityErr;
`endif
    end
  end

  // The commit decision and the occupancy update share the same edge, so a
  // read in the commit cycle cancels the increment and the count holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeMode <= 1'b0;
      packetOut <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      writeMode <= wrAccept;
      overflow  <= commit & full;
      underflow <= readReq & empty;
      if (wrAccept) packetOut <= shiftReg;
      case ({wrAccept, readMode})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  countInRange: assert property (@(posedge clk) disable iff (rst) fifoCount <= SLOTS);

endmodule

// File: tb/tb_serial_packet_writer.sv
// Self-checking bench for serial_packet_writer against a packet-level model.
// Parity scenarios are included when PARITY_CHECK_EN is defined.
module tb_serial_packet_writer;
  logic       clk = 1'b0;
  logic       rst, serialIn, bitValid, frameStart, readReq;
  logic       writeMode, readMode, empty, full, overflow, underflow, frameErr;
  logic [7:0] packetOut;
  logic [3:0] fifoCount;
`ifdef PARITY_CHECK_EN
  logic       parityErr;
`endif

  serial_packet_writer #(.BITS(8), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .serialIn(serialIn), .bitValid(bitValid),
    .frameStart(frameStart), .readReq(readReq), .writeMode(writeMode),
    .packetOut(packetOut), .readMode(readMode), .fifoCount(fifoCount),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
    .frameErr(frameErr)
`ifdef PARITY_CHECK_EN
    , .parityErr(parityErr)
`endif
  );

  always #5 clk = ~clk;

  int nCompared = 0, nMismatch = 0;
  logic [7:0] expQ[$], obsQ[$];
  int modelCount, expOverflow, expUnderflow;
  int obsOverflow, obsUnderflow, obsFrameErr, obsParityErr;

  always @(negedge clk) begin
    if (!rst) begin
      if (writeMode) obsQ.push_back(packetOut);
      if (overflow)  obsOverflow++;
      if (underflow) obsUnderflow++;
      if (frameErr)  obsFrameErr++;
`ifdef PARITY_CHECK_EN
      if (parityErr) obsParityErr++;
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bitValid = 1'b0;
    readReq  = 1'b0;
    repeat (n) begin
      frameStart = 1'($urandom);
      serialIn   = 1'($urandom);
      tick();
    end
    frameStart = 1'b0;
  endtask

  task automatic sendBit(input logic b, input logic fs, input bit stalls);
    if (stalls) idle($urandom_range(0, 2));
    bitValid = 1'b1; serialIn = b; frameStart = fs; readReq = 1'b0;
    tick();
    bitValid = 1'b0; frameStart = 1'b0;
  endtask

  task automatic sendData(input logic [7:0] v, input bit stalls);
    for (int i = 7; i >= 0; i--) sendBit(v[i], (i == 7), stalls);
`ifdef PARITY_CHECK_EN
    sendBit(^v, 1'b0, stalls);
`endif
  endtask

  // Packet-level model: a finished frame is stored when fewer than 8 are held.
  task automatic modelFrame(input logic [7:0] v);
    if (modelCount < 8) begin
      expQ.push_back(v);
      modelCount++;
    end else begin
      expOverflow++;
    end
  endtask

  task automatic sendFrame(input logic [7:0] v);
    sendData(v, 1'b1);
    modelFrame(v);
    idle(2 + $urandom_range(0, 1));
    repeat ($urandom_range(0, 2)) begin
      bitValid = 1'b1; frameStart = 1'b0; serialIn = 1'($urandom);
      tick();
    end
    bitValid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1; bitValid = 1'b0; frameStart = 1'b0; readReq = 1'b0; serialIn = 1'b0;
    tick(); tick();
    rst = 1'b0;
    expQ.delete(); obsQ.delete();
    modelCount = 0; expOverflow = 0; expUnderflow = 0;
    obsOverflow = 0; obsUnderflow = 0; obsFrameErr = 0; obsParityErr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bitValid = 1'b1; frameStart = 1'b1; serialIn = 1'b1; readReq = 1'b1;
    tick(); tick();
    @(negedge clk);
    nCompared++;
    if ({writeMode, packetOut, fifoCount, empty, full, overflow, underflow, frameErr, readMode}
        !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      nMismatch++;
      $display("FAIL reset_state: got wm=%b pkt=%h cnt=%0d e=%b f=%b ov=%b un=%b fe=%b rm=%b expected 0 00 0 1 0 0 0 0 0",
               writeMode, packetOut, fifoCount, empty, full, overflow, underflow, frameErr, readMode);
    end
    rst = 1'b0; bitValid = 1'b0; frameStart = 1'b0; readReq = 1'b0;
    tick();
    doReset();
  endtask

  task automatic test_basic();
    doReset();
    sendData(8'hA5, 1'b0);
    @(negedge clk);
    nCompared++;
    if (writeMode !== 1'b0) begin
      nMismatch++; $display("FAIL latency_early: got writeMode=%b expected 0", writeMode);
    end
    tick();
    @(negedge clk);
    nCompared++;
    if ({writeMode, packetOut, fifoCount, empty} !== {1'b1, 8'hA5, 4'd1, 1'b0}) begin
      nMismatch++;
      $display("FAIL basic_write: got wm=%b pkt=%h cnt=%0d empty=%b expected 1 a5 1 0",
               writeMode, packetOut, fifoCount, empty);
    end
    tick();
    @(negedge clk);
    nCompared++;
    if ({writeMode, packetOut} !== {1'b0, 8'hA5}) begin
      nMismatch++; $display("FAIL basic_hold: got wm=%b pkt=%h expected 0 a5", writeMode, packetOut);
    end
    tick();
  endtask

  task automatic test_fill_overflow();
    doReset();
    for (int i = 0; i < 8; i++) sendFrame(8'($urandom));
    nCompared++;
    if ({fifoCount, full, empty} !== {4'd8, 1'b1, 1'b0}) begin
      nMismatch++; $display("FAIL fill_full: got cnt=%0d full=%b empty=%b expected 8 1 0", fifoCount, full, empty);
    end
    sendFrame(8'($urandom));
    nCompared++;
    if (obsOverflow !== expOverflow || expOverflow != 1) begin
      nMismatch++; $display("FAIL overflow_pulses: got %0d expected %0d", obsOverflow, 1);
    end
    nCompared++;
    if (fifoCount !== 4'd8) begin
      nMismatch++; $display("FAIL overflow_count: got %0d expected 8", fifoCount);
    end
    nCompared++;
    if (obsQ.size() !== expQ.size()) begin
      nMismatch++; $display("FAIL fill_writes: got %0d writes expected %0d", obsQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        nCompared++;
        if (obsQ[i] !== expQ[i]) begin
          nMismatch++; $display("FAIL fill_data[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_underflow_concurrent();
    logic [7:0] v;
    doReset();
    readReq = 1'b1;
    @(negedge clk);
    nCompared++;
    if (readMode !== 1'b0) begin
      nMismatch++; $display("FAIL empty_readMode: got %b expected 0", readMode);
    end
    tick();
    readReq = 1'b0;
    @(negedge clk);
    nCompared++;
    if ({underflow, fifoCount} !== {1'b1, 4'd0}) begin
      nMismatch++; $display("FAIL underflow: got un=%b cnt=%0d expected 1 0", underflow, fifoCount);
    end
    tick();
    for (int i = 0; i < 3; i++) sendFrame(8'($urandom));
    nCompared++;
    if (fifoCount !== 4'd3) begin
      nMismatch++; $display("FAIL three_frames: got %0d expected 3", fifoCount);
    end
    v = 8'($urandom);
    sendData(v, 1'b1);
    readReq = 1'b1;
    @(negedge clk);
    nCompared++;
    if (readMode !== 1'b1) begin
      nMismatch++; $display("FAIL concurrent_readMode: got %b expected 1", readMode);
    end
    tick();
    readReq = 1'b0;
    @(negedge clk);
    nCompared++;
    if ({writeMode, packetOut, fifoCount} !== {1'b1, v, 4'd3}) begin
      nMismatch++; $display("FAIL concurrent_rw: got wm=%b pkt=%h cnt=%0d expected 1 %h 3",
                            writeMode, packetOut, fifoCount, v);
    end
    tick();
  endtask

  task automatic test_frame_err();
    doReset();
    for (int i = 0; i < 4; i++) sendBit(1'($urandom), (i == 0), 1'b1);
    sendFrame(8'h3C);
    nCompared++;
    if (obsFrameErr !== 1) begin
      nMismatch++; $display("FAIL frameErr_pulses: got %0d expected 1", obsFrameErr);
    end
    nCompared++;
    if (obsQ.size() !== 1 || fifoCount !== 4'd1) begin
      nMismatch++; $display("FAIL frameErr_writes: got %0d writes cnt=%0d expected 1 1", obsQ.size(), fifoCount);
    end else begin
      nCompared++;
      if (obsQ[0] !== 8'h3C) begin
        nMismatch++; $display("FAIL frameErr_data: got %h expected 3c", obsQ[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 5; i++) sendBit(1'b1, (i == 0), 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sendFrame(8'hFF);
    nCompared++;
    if (obsQ.size() !== 1 || fifoCount !== 4'd1) begin
      nMismatch++; $display("FAIL resetMid_writes: got %0d writes cnt=%0d expected 1 1", obsQ.size(), fifoCount);
    end else begin
      nCompared++;
      if (obsQ[0] !== 8'hFF) begin
        nMismatch++; $display("FAIL resetMid_data: got %h expected ff", obsQ[0]);
      end
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    doReset();
    sendFrame(8'hA5);
    for (int i = 7; i >= 0; i--) sendBit(((8'hA5 >> i) & 8'h01) != 0, (i == 7), 1'b0);
    sendBit(1'b1, 1'b0, 1'b0);
    idle(3);
    nCompared++;
    if (obsParityErr !== 1) begin
      nMismatch++; $display("FAIL parityErr_pulses: got %0d expected 1", obsParityErr);
    end
    nCompared++;
    if (obsQ.size() !== 1 || fifoCount !== 4'd1) begin
      nMismatch++; $display("FAIL parity_writes: got %0d writes cnt=%0d expected 1 1", obsQ.size(), fifoCount);
    end
  endtask
`endif

  task automatic test_random();
    doReset();
    for (int op = 0; op < 60; op++) begin
      if ($urandom_range(0, 9) < 6) begin
        sendFrame(8'($urandom));
      end else begin
        readReq = 1'b1; bitValid = 1'b0;
        @(negedge clk);
        nCompared++;
        if (readMode !== (modelCount != 0)) begin
          nMismatch++; $display("FAIL rand_readMode op%0d: got %b expected %b", op, readMode, modelCount != 0);
        end
        tick();
        readReq = 1'b0;
        if (modelCount > 0) modelCount--;
        else expUnderflow++;
      end
      nCompared++;
      if (fifoCount !== 4'(modelCount)) begin
        nMismatch++; $display("FAIL rand_count op%0d: got %0d expected %0d", op, fifoCount, modelCount);
      end
    end
    idle(2);
    nCompared++;
    if (obsOverflow !== expOverflow) begin
      nMismatch++; $display("FAIL rand_overflow: got %0d expected %0d", obsOverflow, expOverflow);
    end
    nCompared++;
    if (obsUnderflow !== expUnderflow) begin
      nMismatch++; $display("FAIL rand_underflow: got %0d expected %0d", obsUnderflow, expUnderflow);
    end
    nCompared++;
    if ({full, empty} !== {modelCount == 8, modelCount == 0}) begin
      nMismatch++; $display("FAIL rand_flags: got full=%b empty=%b expected %b %b",
                            full, empty, modelCount == 8, modelCount == 0);
    end
    nCompared++;
    if (obsQ.size() !== expQ.size()) begin
      nMismatch++; $display("FAIL rand_writes: got %0d expected %0d", obsQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        nCompared++;
        if (obsQ[i] !== expQ[i]) begin
          nMismatch++; $display("FAIL rand_data[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; bitValid = 1'b0; frameStart = 1'b0; readReq = 1'b0; serialIn = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_underflow_concurrent();
    test_frame_err();
    test_reset_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
